// File: rtl/vga_pkg.sv
// VGA timing generator: shared timing constants and helpers.
// Default geometry is 640x480@60 with active-low syncs.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT
                             + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT
                             + DEF_V_SYNC + DEF_V_BACK;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_e;

  // Repeat the low w bits of v MSB-first until 8 bits are filled.
  function automatic logic [7:0] expand8(
    input logic [7:0] v,
    input int         w
  );
    logic [7:0] r;
    logic [2:0] j;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      j = 3'(w - 1 - (i % w));
      r[3'(7 - i)] = v[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA timing generator: pixel request and DAC bundle.
// master = generator side, slave = pixel source / DAC side.
interface vga_timing_gen_if #(
  parameter int CW = 8
) ();
  logic [CW-1:0] color_in;
  logic [9:0]    next_x;
  logic [9:0]    next_y;
  logic          pix_req;
  logic          hsync;
  logic          vsync;
  logic          blank_n;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          frame_start;
  logic          line_start;
  logic          sync_n;
  logic          vga_clk;

  modport master (
    input  color_in,
    output next_x, next_y, pix_req,
    output hsync, vsync, blank_n,
    output red, green, blue,
    output frame_start, line_start,
    output sync_n, vga_clk
  );

  modport slave (
    output color_in,
    input  next_x, next_y, pix_req,
    input  hsync, vsync, blank_n,
    input  red, green, blue,
    input  frame_start, line_start,
    input  sync_n, vga_clk
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// VGA timing generator: one raster axis counter.
// Counts 0..TOTAL-1 on enable and decodes active/sync regions.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             active_o,
  output logic             sync_o
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_len
    $error("vga_axis_counter: zero-length region");
  end
  if (TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_axis_counter: total exceeds counter width");
  end

  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(ACTIVE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  region_e          region;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    region = REG_BACK;
    unique case (1'b1)
      (cnt_q < ACT_END):
        region = REG_ACTIVE;
      (cnt_q >= ACT_END && cnt_q < SYNC_LO):
        region = REG_FRONT;
      (cnt_q >= SYNC_LO && cnt_q < SYNC_HI):
        region = REG_SYNC;
      default:
        region = REG_BACK;
    endcase
  end

  assign cnt_o    = cnt_q;
  assign active_o = (region == REG_ACTIVE);
  assign sync_o   = (region == REG_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator top: raster counters and 1-tick output stage.
// Pixels are requested combinationally; sync and colour leave aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic H_POL    = POL_LOW,
  parameter logic V_POL    = POL_LOW,
  parameter int   R_W      = 3,
  parameter int   G_W      = 3,
  parameter int   B_W      = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pix_en,
  vga_timing_gen_if.master    vga
);

  localparam int CW = R_W + G_W + B_W;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, h_sync, v_act, v_sync;
  logic             v_en, pix_req;
  logic [7:0]       r_x, g_x, b_x;

  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       blank_q, blank_d, fs_q, fs_d, ls_q, ls_d;
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  // Vertical axis steps on the last pixel tick of each line.
  assign v_en = pix_en && (h_cnt == H_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
    .SYNC(H_SYNC),     .BACK(H_BACK)
  ) u_h (
    .clock(clock), .reset(reset), .en_i(pix_en),
    .cnt_o(h_cnt), .active_o(h_act), .sync_o(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
    .SYNC(V_SYNC),     .BACK(V_BACK)
  ) u_v (
    .clock(clock), .reset(reset), .en_i(v_en),
    .cnt_o(v_cnt), .active_o(v_act), .sync_o(v_sync)
  );

  assign pix_req = h_act && v_act;

  assign r_x = expand8(8'(vga.color_in[CW-1 -: R_W]), R_W);
  assign g_x = expand8(8'(vga.color_in[G_W+B_W-1 -: G_W]), G_W);
  assign b_x = expand8(8'(vga.color_in[B_W-1:0]), B_W);

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    fs_d    = fs_q;
    ls_d    = ls_q;
    if (pix_en) begin
      hsync_d = h_sync ? H_POL : ~H_POL;
      vsync_d = v_sync ? V_POL : ~V_POL;
      blank_d = pix_req;
      red_d   = pix_req ? r_x : 8'h00;
      green_d = pix_req ? g_x : 8'h00;
      blue_d  = pix_req ? b_x : 8'h00;
      ls_d    = pix_req && (h_cnt == '0);
      fs_d    = pix_req && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      blank_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign vga.next_x      = pix_req ? h_cnt : '0;
  assign vga.next_y      = pix_req ? v_cnt : '0;
  assign vga.pix_req     = pix_req;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;
  // Strobes are qualified so they last one pixel tick, not one clock.
  assign vga.frame_start = fs_q && pix_en;
  assign vga.line_start  = ls_q && pix_en;
  assign vga.sync_n      = 1'b0;
  assign vga.vga_clk     = clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 instance plus a
// tiny-geometry 8-bit-colour instance, directed checks per feature.
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pe    = 1'b1;
  logic pe_s  = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vga_timing_gen_if #(.CW(8))  bus   ();
  vga_timing_gen_if #(.CW(24)) bus_s ();

  vga_timing_gen dut (
    .clock(clock), .reset(reset), .pix_en(pe), .vga(bus)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b0),
    .R_W(8), .G_W(8), .B_W(8)
  ) dut_s (
    .clock(clock), .reset(reset), .pix_en(pe_s), .vga(bus_s)
  );

  task automatic do_reset();
    reset = 1'b1;
    pe    = 1'b1;
    pe_s  = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pe    = 1'b1;
    pe_s  = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync got h=%b v=%b exp h=1 v=1",
               bus.hsync, bus.vsync);
    end
    checks++;
    if (bus.blank_n !== 1'b0 || bus.red !== 8'h00 ||
        bus.green !== 8'h00 || bus.blue !== 8'h00) begin
      failures++;
      $display("FAIL reset_rgb got blank=%b rgb=%h%h%h exp 0 000000",
               bus.blank_n, bus.red, bus.green, bus.blue);
    end
    checks++;
    if (bus.frame_start !== 1'b0 || bus.line_start !== 1'b0 ||
        bus.next_x !== 10'd0 || bus.next_y !== 10'd0) begin
      failures++;
      $display("FAIL reset_misc got fs=%b ls=%b x=%0d y=%0d exp 0 0 0 0",
               bus.frame_start, bus.line_start, bus.next_x, bus.next_y);
    end
    checks++;
    if (bus_s.hsync !== 1'b0 || bus_s.vsync !== 1'b1) begin
      failures++;
      $display("FAIL reset_small_sync got h=%b v=%b exp h=0 v=1",
               bus_s.hsync, bus_s.vsync);
    end
    checks++;
    if (bus.sync_n !== 1'b0 || bus.vga_clk !== clock) begin
      failures++;
      $display("FAIL const_outs got sync_n=%b vga_clk=%b exp 0 %b",
               bus.sync_n, bus.vga_clk, clock);
    end
    reset = 1'b0;
  endtask

  task automatic test_hsync();
    int fall1, fall2, lows, vlows, fs_cnt, ls_cnt;
    logic prev;
    fall1 = 0; fall2 = 0; lows = 0; vlows = 0;
    fs_cnt = 0; ls_cnt = 0;
    bus.color_in = 8'hFF;
    do_reset();
    prev = bus.hsync;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clock);
      if (bus.hsync === 1'b0) lows++;
      if (bus.vsync === 1'b0) vlows++;
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (bus.line_start === 1'b1) ls_cnt++;
      if (prev === 1'b1 && bus.hsync === 1'b0) begin
        if (fall1 == 0) fall1 = n;
        else if (fall2 == 0) fall2 = n;
      end
      prev = bus.hsync;
      if (n == 1) begin
        checks++;
        if (bus.frame_start !== 1'b1) begin
          failures++;
          $display("FAIL frame_start_first got %b exp 1", bus.frame_start);
        end
      end
      if (n == 100) begin
        checks++;
        if (bus.next_x !== 10'd100 || bus.pix_req !== 1'b1) begin
          failures++;
          $display("FAIL next_x_100 got x=%0d req=%b exp 100 1",
                   bus.next_x, bus.pix_req);
        end
      end
      if (n == 640 || n == 641) begin
        checks++;
        if (bus.blank_n !== (n == 640)) begin
          failures++;
          $display("FAIL blank_edge n=%0d got %b exp %b",
                   n, bus.blank_n, (n == 640));
        end
      end
      if (n == 700) begin
        checks++;
        if (bus.next_x !== 10'd0 || bus.pix_req !== 1'b0) begin
          failures++;
          $display("FAIL porch_req got x=%0d req=%b exp 0 0",
                   bus.next_x, bus.pix_req);
        end
      end
      if (n == 900) begin
        checks++;
        if (bus.next_x !== 10'd100 || bus.next_y !== 10'd1) begin
          failures++;
          $display("FAIL line1_xy got x=%0d y=%0d exp 100 1",
                   bus.next_x, bus.next_y);
        end
      end
    end
    checks++;
    if (fall1 != 657 || fall2 != 1457) begin
      failures++;
      $display("FAIL hsync_fall got %0d,%0d exp 657,1457", fall1, fall2);
    end
    checks++;
    if (lows != 192) begin
      failures++;
      $display("FAIL hsync_width got %0d exp 192", lows);
    end
    checks++;
    if (vlows != 0 || fs_cnt != 1 || ls_cnt != 3) begin
      failures++;
      $display("FAIL strobes got vlow=%0d fs=%0d ls=%0d exp 0 1 3",
               vlows, fs_cnt, ls_cnt);
    end
  endtask

  task automatic test_color();
    bus.color_in = 8'hFF;
    do_reset();
    for (int n = 1; n <= 700; n++) begin
      @(negedge clock);
      if (n == 5) begin
        checks++;
        if (bus.red !== 8'hFF || bus.green !== 8'hFF ||
            bus.blue !== 8'hFF || bus.blank_n !== 1'b1) begin
          failures++;
          $display("FAIL rgb_ff got %h %h %h b=%b exp FF FF FF 1",
                   bus.red, bus.green, bus.blue, bus.blank_n);
        end
      end
      if (n == 10) begin
        checks++;
        if (bus.red !== 8'hFF) begin
          failures++;
          $display("FAIL rgb_latency got %h exp FF", bus.red);
        end
        bus.color_in = 8'b101_010_10;
      end
      if (n == 11) begin
        checks++;
        if (bus.red !== 8'hB6 || bus.green !== 8'h49 ||
            bus.blue !== 8'hAA) begin
          failures++;
          $display("FAIL rgb_expand got %h %h %h exp B6 49 AA",
                   bus.red, bus.green, bus.blue);
        end
      end
      if (n == 700) begin
        checks++;
        if (bus.red !== 8'h00 || bus.green !== 8'h00 ||
            bus.blue !== 8'h00 || bus.blank_n !== 1'b0) begin
          failures++;
          $display("FAIL rgb_porch got %h %h %h b=%b exp 00 00 00 0",
                   bus.red, bus.green, bus.blue, bus.blank_n);
        end
      end
    end
  endtask

  task automatic test_pix_en_toggle();
    int first_low, lows, fs_cnt;
    first_low = 0; lows = 0; fs_cnt = 0;
    bus.color_in = 8'hFF;
    do_reset();
    for (int n = 1; n <= 1600; n++) begin
      @(negedge clock);
      if (bus.hsync === 1'b0) begin
        lows++;
        if (first_low == 0) first_low = n;
      end
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (n == 2 || n == 3) begin
        checks++;
        if (bus.next_x !== 10'(n - 1) || bus.blank_n !== 1'b1) begin
          failures++;
          $display("FAIL toggle_hold n=%0d got x=%0d b=%b exp %0d 1",
                   n, bus.next_x, bus.blank_n, n - 1);
        end
      end
      pe = (n % 2 == 0);
    end
    pe = 1'b1;
    checks++;
    if (first_low != 1313 || lows != 192) begin
      failures++;
      $display("FAIL toggle_hsync got start=%0d len=%0d exp 1313 192",
               first_low, lows);
    end
    checks++;
    if (fs_cnt != 1) begin
      failures++;
      $display("FAIL toggle_fs got %0d exp 1", fs_cnt);
    end
  endtask

  task automatic test_small();
    int exp_x[7];
    int hs_hi, vs_lo, fs_cnt, ls_cnt, req_cnt;
    exp_x = '{0, 1, 2, 3, 0, 0, 0};
    hs_hi = 0; vs_lo = 0; fs_cnt = 0; ls_cnt = 0; req_cnt = 0;
    bus_s.color_in = 24'h123456;
    do_reset();
    for (int n = 0; n <= 84; n++) begin
      if (n > 0) @(negedge clock);
      if (n < 7) begin
        checks++;
        if (bus_s.next_x !== 10'(exp_x[n])) begin
          failures++;
          $display("FAIL small_next_x n=%0d got %0d exp %0d",
                   n, bus_s.next_x, exp_x[n]);
        end
      end
      if (n <= 41 && bus_s.pix_req === 1'b1) req_cnt++;
      if (n >= 1 && n <= 42) begin
        if (bus_s.hsync === 1'b1) hs_hi++;
        if (bus_s.vsync === 1'b0) vs_lo++;
        if (bus_s.line_start === 1'b1) ls_cnt++;
      end
      if (n >= 1 && bus_s.frame_start === 1'b1) fs_cnt++;
      if (n == 1) begin
        checks++;
        if (bus_s.red !== 8'h12 || bus_s.green !== 8'h34 ||
            bus_s.blue !== 8'h56) begin
          failures++;
          $display("FAIL small_rgb8 got %h %h %h exp 12 34 56",
                   bus_s.red, bus_s.green, bus_s.blue);
        end
      end
      if (n == 5) begin
        checks++;
        if (bus_s.red !== 8'h00 || bus_s.blank_n !== 1'b0) begin
          failures++;
          $display("FAIL small_porch got r=%h b=%b exp 00 0",
                   bus_s.red, bus_s.blank_n);
        end
      end
      if (n == 43) begin
        checks++;
        if (bus_s.frame_start !== 1'b1) begin
          failures++;
          $display("FAIL small_fs_43 got %b exp 1", bus_s.frame_start);
        end
      end
    end
    checks++;
    if (hs_hi != 6 || vs_lo != 7) begin
      failures++;
      $display("FAIL small_sync got hhi=%0d vlo=%0d exp 6 7", hs_hi, vs_lo);
    end
    checks++;
    if (fs_cnt != 2 || ls_cnt != 3 || req_cnt != 12) begin
      failures++;
      $display("FAIL small_counts got fs=%0d ls=%0d req=%0d exp 2 3 12",
               fs_cnt, ls_cnt, req_cnt);
    end
  endtask

  task automatic test_mid_reset();
    bus_s.color_in = 24'hABCDEF;
    do_reset();
    repeat (9) @(negedge clock);
    checks++;
    if (bus_s.next_x !== 10'd2 || bus_s.next_y !== 10'd1) begin
      failures++;
      $display("FAIL mid_pos got x=%0d y=%0d exp 2 1",
               bus_s.next_x, bus_s.next_y);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus_s.next_x !== 10'd0 || bus_s.next_y !== 10'd0 ||
        bus_s.hsync !== 1'b0 || bus_s.blank_n !== 1'b0 ||
        bus_s.red !== 8'h00 || bus_s.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got x=%0d y=%0d h=%b b=%b r=%h fs=%b exp 0 0 0 0 00 0",
               bus_s.next_x, bus_s.next_y, bus_s.hsync,
               bus_s.blank_n, bus_s.red, bus_s.frame_start);
    end
    reset = 1'b0;
    pe_s  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bus_s.frame_start !== 1'b0 || bus_s.next_x !== 10'd0) begin
        failures++;
        $display("FAIL mid_hold k=%0d got fs=%b x=%0d exp 0 0",
                 k, bus_s.frame_start, bus_s.next_x);
      end
    end
    pe_s = 1'b1;
    @(negedge clock);
    checks++;
    if (bus_s.frame_start !== 1'b1 || bus_s.blank_n !== 1'b1 ||
        bus_s.next_x !== 10'd1 || bus_s.red !== 8'hAB) begin
      failures++;
      $display("FAIL mid_restart got fs=%b b=%b x=%0d r=%h exp 1 1 1 AB",
               bus_s.frame_start, bus_s.blank_n, bus_s.next_x, bus_s.red);
    end
    @(negedge clock);
    checks++;
    if (bus_s.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_fs_pulse got %b exp 0", bus_s.frame_start);
    end
  endtask

  initial begin
    bus.color_in   = 8'h00;
    bus_s.color_in = 24'h000000;
    @(negedge clock);
    test_reset();
    test_hsync();
    test_color();
    test_pix_en_toggle();
    test_small();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
